reorder_buffer: RTL and testbench

Parametrised circular reorder buffer for the out-of-order core; it is the next generation of the fixed small ROB. It allocates entries in program order from issue, captures results from the common data bus (CDB) by ROB tag, and retires the head entry in order. Retirement is one of three actions: a register write to the regfile, a store to the store-memory unit, or a branch resolution that flushes the machine on mispredict. It sits between issue/reservation stations (alloc side, CDB side) and regfile/store unit (commit side).

---
 rtl/rob_pkg.sv | 34 +++
 rtl/rob_ptr.sv | 29 ++
 rtl/reorder_buffer.sv | 161 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: destination kind, per-entry status, default sizes.
// Combinational helpers only; no storage, no handshakes.
// Raw 2-bit alloc type codes are folded onto the enum here so reserved values behave as branches.
package rob_pkg;

  localparam int ROB_DEPTH_DEF  = 8;
  localparam int ROB_DATA_W_DEF = 64;
  localparam int ROB_ADDR_W_DEF = 64;
  localparam int ROB_REG_W_DEF  = 5;

  typedef enum logic [1:0] {
    ROB_NONE  = 2'd0,
    ROB_REG   = 2'd1,
    ROB_STORE = 2'd2
  } rob_type_e;

  typedef struct packed {
    logic      valid;
    logic      ready;
    rob_type_e typ;
    logic      mispredict;
  } rob_status_t;

  function automatic rob_type_e rob_decode_type(input logic [1:0] raw);
    rob_type_e t;
    case (raw)
      2'd1:    t = ROB_REG;
      2'd2:    t = ROB_STORE;
      default: t = ROB_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrapping W-bit pointer with increment and synchronous clear (clear wins).
// Latency: new value visible the cycle after inc/clr.
// Backpressure: none; the caller gates inc.
module rob_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)      ptr_d = '0;
    else if (inc) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// Circular ROB: in-order alloc, CDB capture by tag, in-order retire; ROB_BYPASS_EN adds head capture-to-commit bypass.
// Latency: CDB capture to commit is 1 cycle (0 with ROB_BYPASS_EN); one retire per cycle at most.
// Backpressure: alloc_ready drops when full or flushing; a store head stalls until st_ready.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH_DEF,
  parameter int DATA_W = ROB_DATA_W_DEF,
  parameter int ADDR_W = ROB_ADDR_W_DEF,
  parameter int REG_W  = ROB_REG_W_DEF,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [1:0]        alloc_type,
  input  logic [ADDR_W-1:0] alloc_dst,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_mispredict,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_dst,
  output logic [TAG_W-1:0]  rf_tag,
  output logic [DATA_W-1:0] rf_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [ADDR_W-1:0] st_addr,
  output logic [DATA_W-1:0] st_data,
  output logic              flush,
  output logic [TAG_W:0]    count,
  output logic              empty
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] ONE_CNT  = (TAG_W+1)'(1);

  rob_status_t       st_q  [DEPTH];
  logic [ADDR_W-1:0] dst_q [DEPTH];
  logic [DATA_W-1:0] val_q [DEPTH];

  logic [TAG_W:0]    count_q, count_d;
  logic [TAG_W-1:0]  head, tail;
  rob_status_t       head_st;
  logic              head_commit;
  logic [DATA_W-1:0] commit_data;
  logic              commit_misp;
  logic              do_alloc, do_capture, retire;

  assign head_st = st_q[head];

`ifdef ROB_BYPASS_EN
  logic bypass;
  assign bypass      = head_st.valid & ~head_st.ready & cdb_valid & (cdb_tag == head);
  assign head_commit = head_st.valid & (head_st.ready | bypass);
  assign commit_data = head_st.ready ? val_q[head] : cdb_data;
  assign commit_misp = head_st.ready ? head_st.mispredict : cdb_mispredict;
`else
  assign head_commit = head_st.valid & head_st.ready;
  assign commit_data = val_q[head];
  assign commit_misp = head_st.mispredict;
`endif

  // Commit decode; every output idles at zero when the head is not retiring.
  always_comb begin
    rf_we    = 1'b0;
    rf_dst   = '0;
    rf_tag   = '0;
    rf_data  = '0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    flush    = 1'b0;
    retire   = 1'b0;
    if (head_commit) begin
      case (head_st.typ)
        ROB_REG: begin
          rf_we   = 1'b1;
          rf_dst  = dst_q[head][REG_W-1:0];
          rf_tag  = head;
          rf_data = commit_data;
          retire  = 1'b1;
        end
        ROB_STORE: begin
          st_valid = 1'b1;
          st_addr  = dst_q[head];
          st_data  = commit_data;
          retire   = st_ready;
        end
        default: begin
          flush  = commit_misp;
          retire = 1'b1;
        end
      endcase
    end
  end

  assign alloc_ready = (count_q != FULL_CNT) & ~flush;
  assign do_alloc    = alloc_valid & alloc_ready;
  assign do_capture  = cdb_valid & st_q[cdb_tag].valid & ~st_q[cdb_tag].ready;

  always_comb begin
    count_d = count_q;
    if (flush)                  count_d = '0;
    else if (do_alloc & ~retire) count_d = count_q + ONE_CNT;
    else if (~do_alloc & retire) count_d = count_q - ONE_CNT;
  end

  // Alloc targets an invalid slot and retire a valid one, so the three writes never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]  <= '0;
        dst_q[i] <= '0;
        val_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) st_q[i].valid <= 1'b0;
    end else begin
      if (do_capture) begin
        st_q[cdb_tag].ready      <= 1'b1;
        st_q[cdb_tag].mispredict <= cdb_mispredict;
        val_q[cdb_tag]           <= cdb_data;
      end
      if (retire) st_q[head].valid <= 1'b0;
      if (do_alloc) begin
        st_q[tail] <= '{valid: 1'b1, ready: 1'b0,
                        typ: rob_decode_type(alloc_type), mispredict: 1'b0};
        dst_q[tail] <= alloc_dst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  rob_ptr #(.W(TAG_W)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .clr   (flush),
    .ptr   (head)
  );

  rob_ptr #(.W(TAG_W)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (do_alloc),
    .clr   (flush),
    .ptr   (tail)
  );

  assign alloc_tag = tail;
  assign count     = count_q;
  assign empty     = (count_q == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: DEPTH=8 instance for function, DEPTH=4 instance for wrap.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic [1:0]  alloc_type;
  logic [63:0] alloc_dst;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        cdb_mispredict;
  logic        st_ready;

  logic        alloc_ready, rf_we, st_valid, flush, empty;
  logic [2:0]  alloc_tag, rf_tag;
  logic [4:0]  rf_dst;
  logic [63:0] rf_data, st_addr, st_data;
  logic [3:0]  count;

  logic        alloc_ready4, rf_we4, st_valid4, flush4, empty4;
  logic [1:0]  alloc_tag4, rf_tag4;
  logic [4:0]  rf_dst4;
  logic [63:0] rf_data4, st_addr4, st_data4;
  logic [2:0]  count4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_type(alloc_type),
    .alloc_dst(alloc_dst), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_mispredict(cdb_mispredict),
    .rf_we(rf_we), .rf_dst(rf_dst), .rf_tag(rf_tag), .rf_data(rf_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .flush(flush), .count(count), .empty(empty)
  );

  reorder_buffer #(.DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready4), .alloc_type(alloc_type),
    .alloc_dst(alloc_dst), .alloc_tag(alloc_tag4),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag[1:0]), .cdb_data(cdb_data), .cdb_mispredict(cdb_mispredict),
    .rf_we(rf_we4), .rf_dst(rf_dst4), .rf_tag(rf_tag4), .rf_data(rf_data4),
    .st_valid(st_valid4), .st_ready(st_ready), .st_addr(st_addr4), .st_data(st_data4),
    .flush(flush4), .count(count4), .empty(empty4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    alloc_valid    = 1'b0;
    cdb_valid      = 1'b0;
    cdb_mispredict = 1'b0;
    st_ready       = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [1:0]  btype [6];
    logic [2:0]  ctag  [6];
    logic        cmis  [6];
    rst_n = 1'b0;
    drive_idle();
    alloc_type = 2'd0;
    alloc_dst  = '0;
    cdb_tag    = '0;
    cdb_data   = '0;

    // Reset state
    #12;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_st_valid", st_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_st_addr", st_addr, 0);
    rst_n = 1'b1;
    tick();

    // Fill all 8 entries with register ops
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1;
      alloc_type  = 2'd1;
      alloc_dst   = 64'(8 + i);
      #1;
      chk("fill_tag", alloc_tag, i);
      chk("fill_ready", alloc_ready, 1);
      tick();
    end
    #1;
    chk("full_alloc_ready", alloc_ready, 0);
    chk("full_count", count, 8);
    chk("full_empty", empty, 0);
    tick();
    chk("full_count_hold", count, 8);
    alloc_valid = 1'b0;

    // Out-of-order CDB, in-order commit
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 64'hA;
    #1;
    chk("ooo_no_commit1", rf_we, 0);
    tick();
    cdb_tag = 3'd0; cdb_data = 64'hB;
    #1;
    chk("ooo_no_commit2", rf_we, 0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("commit0_we", rf_we, 1);
    chk("commit0_dst", rf_dst, 8);
    chk("commit0_tag", rf_tag, 0);
    chk("commit0_data", rf_data, 64'hB);
    tick();
    chk("commit1_we", rf_we, 1);
    chk("commit1_dst", rf_dst, 9);
    chk("commit1_tag", rf_tag, 1);
    chk("commit1_data", rf_data, 64'hA);
    chk("commit1_count", count, 7);
    tick();
    chk("idle_we", rf_we, 0);
    chk("idle_data", rf_data, 0);
    chk("idle_count", count, 6);
    chk("idle_alloc_ready", alloc_ready, 1);

    // Store held by st_ready
    do_reset();
    tick();
    alloc_valid = 1'b1; alloc_type = 2'd2; alloc_dst = 64'h1000_0040;
    tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 64'hDEAD_BEEF;
    #1;
    chk("st_not_ready_yet", st_valid, 0);
    tick();
    cdb_valid = 1'b0; st_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_hold_valid", st_valid, 1);
      chk("st_hold_addr", st_addr, 64'h1000_0040);
      chk("st_hold_data", st_data, 64'hDEAD_BEEF);
      chk("st_hold_rf_we", rf_we, 0);
      chk("st_hold_count", count, 1);
      tick();
    end
    st_ready = 1'b1;
    #1;
    chk("st_accept_valid", st_valid, 1);
    tick();
    st_ready = 1'b0;
    #1;
    chk("st_done_valid", st_valid, 0);
    chk("st_done_count", count, 0);
    chk("st_done_empty", empty, 1);
    chk("st_done_addr", st_addr, 0);

    // Mispredicted branch at tag 2 with younger ready entries
    do_reset();
    tick();
    btype = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    for (int i = 0; i < 6; i++) begin
      alloc_valid = 1'b1; alloc_type = btype[i]; alloc_dst = 64'(17 + i);
      tick();
    end
    alloc_valid = 1'b0;
    ctag = '{3'd3, 3'd4, 3'd5, 3'd2, 3'd0, 3'd1};
    cmis = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      cdb_valid = 1'b1; cdb_tag = ctag[k]; cdb_data = 64'(8'h30 + k); cdb_mispredict = cmis[k];
      #1;
      chk("br_pre_flush", flush, 0);
      chk("br_pre_rf_we", rf_we, 0);
      tick();
    end
    cdb_valid = 1'b0; cdb_mispredict = 1'b0;
    #1;
    chk("br_silent_flush", flush, 0);
    chk("br_silent_rf_we", rf_we, 0);
    chk("br_silent_count", count, 5);
    tick();
    alloc_valid = 1'b1; alloc_type = 2'd1; alloc_dst = 64'd30;
    #1;
    chk("br_flush", flush, 1);
    chk("br_flush_alloc_ready", alloc_ready, 0);
    chk("br_flush_rf_we", rf_we, 0);
    chk("br_flush_count", count, 4);
    tick();
    alloc_valid = 1'b0;
    #1;
    chk("br_after_flush", flush, 0);
    chk("br_after_count", count, 0);
    chk("br_after_empty", empty, 1);
    chk("br_after_tag", alloc_tag, 0);
    for (int k = 0; k < 3; k++) begin
      chk("br_no_stale_commit", rf_we, 0);
      tick();
    end
    alloc_valid = 1'b1; alloc_type = 2'd1; alloc_dst = 64'd7;
    #1;
    chk("br_realloc_tag", alloc_tag, 0);
    tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 64'h77;
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("br_realloc_we", rf_we, 1);
    chk("br_realloc_dst", rf_dst, 7);
    chk("br_realloc_data", rf_data, 64'h77);

    // DEPTH=4 fill/drain three times
    do_reset();
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        alloc_valid = 1'b1; alloc_type = 2'd1; alloc_dst = 64'(r * 4 + i);
        #1;
        chk("w4_alloc_tag", alloc_tag4, i);
        tick();
      end
      alloc_valid = 1'b0;
      #1;
      chk("w4_full_ready", alloc_ready4, 0);
      chk("w4_full_count", count4, 4);
      for (int i = 0; i < 4; i++) begin
        cdb_valid = 1'b1; cdb_tag = 3'(i); cdb_data = 64'(8'h40 + r * 4 + i);
        #1;
        if (i > 0) begin
          chk("w4_drain_we", rf_we4, 1);
          chk("w4_drain_tag", rf_tag4, i - 1);
          chk("w4_drain_data", rf_data4, 64'(8'h40 + r * 4 + i - 1));
        end
        tick();
      end
      cdb_valid = 1'b0;
      #1;
      chk("w4_last_tag", rf_tag4, 3);
      chk("w4_last_data", rf_data4, 64'(8'h40 + r * 4 + 3));
      tick();
      chk("w4_drained_count", count4, 0);
      chk("w4_drained_empty", empty4, 1);
    end

    // DEPTH=4 steady stream: alloc and commit together keep count at 2
    for (int j = 0; j < 10; j++) begin
      alloc_valid = 1'b1; alloc_type = 2'd1; alloc_dst = 64'(j);
      cdb_valid = (j >= 1);
      cdb_tag   = 3'((j + 3) % 4);
      cdb_data  = 64'(12'h100 + j - 1);
      #1;
      chk("ss_alloc_tag", alloc_tag4, j % 4);
      if (j >= 2) begin
        chk("ss_we", rf_we4, 1);
        chk("ss_tag", rf_tag4, (j - 2) % 4);
        chk("ss_dst", rf_dst4, j - 2);
        chk("ss_data", rf_data4, 64'(12'h100 + j - 2));
        chk("ss_count", count4, 2);
      end
      tick();
    end
    drive_idle();

    // Capture-to-commit latency on the head
    do_reset();
    tick();
    alloc_valid = 1'b1; alloc_type = 2'd1; alloc_dst = 64'd3;
    tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 64'h55;
    #1;
`ifdef ROB_BYPASS_EN
    chk("byp_same_we", rf_we, 1);
    chk("byp_same_data", rf_data, 64'h55);
`else
    chk("nobyp_same_we", rf_we, 0);
    chk("nobyp_same_data", rf_data, 0);
`endif
    tick();
    cdb_valid = 1'b0;
    #1;
`ifdef ROB_BYPASS_EN
    chk("byp_next_we", rf_we, 0);
    chk("byp_next_count", count, 0);
`else
    chk("nobyp_next_we", rf_we, 1);
    chk("nobyp_next_data", rf_data, 64'h55);
    chk("nobyp_next_count", count, 1);
`endif
    tick();

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_type = 2'd1; alloc_dst = 64'(i);
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    chk("arst_pre_count", count, 3);
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_tag", alloc_tag, 0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
